// File: rtl/lock_key_table.sv
// Key-lock responder: grants/blocks obtain requests against a table of held keys.
// Optional LOCK_KEY_TABLE_STATS_EN builds saturating grant/block counters.
module lock_key_table #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LOCKS  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        proc_key,
  input  logic                         proc_obtain_key,
  output logic                         proc_key_grant,
  output logic                         proc_key_blocked,
  output logic                         locks_available,
  input  logic                         release_valid,
  input  logic [DATA_WIDTH-1:0]        release_key,
  output logic                         release_miss,
  output logic [$clog2(NUM_LOCKS):0]   num_locked,
  output logic [31:0]                  stat_grant_count,
  output logic [31:0]                  stat_block_count
);

  localparam int IW = $clog2(NUM_LOCKS);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESPOND,
    S_WAIT
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] req_key_q;
  logic                  hit_q, any_free_q;
  logic [IW-1:0]         free_idx_q;
  logic [NUM_LOCKS-1:0]  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] key_q [NUM_LOCKS];
  logic                  grant_q, block_q, miss_q, avail_q;
  logic [CW-1:0]         num_q, num_d;

  logic                  hit_c, any_free_c;
  logic [IW-1:0]         free_idx_c;
  logic [NUM_LOCKS-1:0]  rel_vec;
  logic                  rel_hit;
  logic                  alloc_en, block_en;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (proc_obtain_key) state_d = S_LOOKUP;
      S_LOOKUP:  state_d = S_RESPOND;
      S_RESPOND: state_d = S_WAIT;
      S_WAIT:    if (!proc_obtain_key) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    alloc_en = 1'b0;
    block_en = 1'b0;
    if (state_q == S_RESPOND) begin
      alloc_en = !hit_q && any_free_q;
      block_en = !alloc_en;
    end
  end

  // Descending scan so the lowest free index wins
  always_comb begin
    hit_c      = 1'b0;
    any_free_c = 1'b0;
    free_idx_c = '0;
    for (int i = NUM_LOCKS - 1; i >= 0; i--) begin
      if (valid_q[i] && key_q[i] == req_key_q) hit_c = 1'b1;
      if (!valid_q[i]) begin
        any_free_c = 1'b1;
        free_idx_c = IW'(i);
      end
    end
  end

  always_comb begin
    rel_vec = '0;
    for (int i = 0; i < NUM_LOCKS; i++) begin
      rel_vec[i] = release_valid && valid_q[i] && key_q[i] == release_key;
    end
    rel_hit = |rel_vec;
  end

  always_comb begin
    valid_d = valid_q & ~rel_vec;
    if (alloc_en) valid_d[free_idx_q] = 1'b1;
    num_d = num_q;
    if (alloc_en && !rel_hit)      num_d = num_q + CW'(1);
    else if (!alloc_en && rel_hit) num_d = num_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_key_q  <= '0;
      hit_q      <= 1'b0;
      any_free_q <= 1'b0;
      free_idx_q <= '0;
    end else begin
      if (state_q == S_IDLE && proc_obtain_key) req_key_q <= proc_key;
      if (state_q == S_LOOKUP) begin
        hit_q      <= hit_c;
        any_free_q <= any_free_c;
        free_idx_q <= free_idx_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      num_q   <= '0;
      avail_q <= 1'b1;
      grant_q <= 1'b0;
      block_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      num_q   <= num_d;
      avail_q <= ~&valid_d;
      grant_q <= alloc_en;
      block_q <= block_en;
      miss_q  <= release_valid && !rel_hit;
    end
  end

  // Key storage needs no reset; valid bits qualify it
  always_ff @(posedge clk) begin
    if (alloc_en) key_q[free_idx_q] <= req_key_q;
  end

  assign proc_key_grant   = grant_q;
  assign proc_key_blocked = block_q;
  assign release_miss     = miss_q;
  assign locks_available  = avail_q;
  assign num_locked       = num_q;

`ifdef LOCK_KEY_TABLE_STATS_EN
  logic [31:0] sg_q, sb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sg_q <= '0;
      sb_q <= '0;
    end else begin
      if (alloc_en && sg_q != '1) sg_q <= sg_q + 32'd1;
      if (block_en && sb_q != '1) sb_q <= sb_q + 32'd1;
    end
  end

  assign stat_grant_count = sg_q;
  assign stat_block_count = sb_q;
`else
  assign stat_grant_count = '0;
  assign stat_block_count = '0;
`endif

endmodule

// File: tb/tb_lock_key_table.sv
// Bench for lock_key_table: directed handshake cases plus random traffic
// checked every cycle against a set-based model of the lock table.
module tb_lock_key_table;

  localparam int DW = 32;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] proc_key;
  logic          proc_obtain_key;
  logic          proc_key_grant;
  logic          proc_key_blocked;
  logic          locks_available;
  logic          release_valid;
  logic [DW-1:0] release_key;
  logic          release_miss;
  logic [3:0]    num_locked;
  logic [31:0]   stat_grant_count;
  logic [31:0]   stat_block_count;

  lock_key_table #(.DATA_WIDTH(DW), .NUM_LOCKS(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .proc_key         (proc_key),
    .proc_obtain_key  (proc_obtain_key),
    .proc_key_grant   (proc_key_grant),
    .proc_key_blocked (proc_key_blocked),
    .locks_available  (locks_available),
    .release_valid    (release_valid),
    .release_key      (release_key),
    .release_miss     (release_miss),
    .num_locked       (num_locked),
    .stat_grant_count (stat_grant_count),
    .stat_block_count (stat_block_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Model: set of held keys plus one outstanding request
  logic [DW-1:0] tbl[$];
  bit            busy;
  int            age;
  logic [DW-1:0] m_key;
  bit            m_dec;
  bit            e_grant, e_block, e_miss;
  int unsigned   m_sg, m_sb;

  task automatic check(string nm, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int find(logic [DW-1:0] k);
    foreach (tbl[i]) if (tbl[i] == k) return i;
    return -1;
  endfunction

  task automatic model_clear();
    tbl.delete();
    busy = 0; age = 0;
    e_grant = 0; e_block = 0; e_miss = 0;
    m_sg = 0; m_sb = 0;
  endtask

  task automatic model_edge();
    int idx;
    e_grant = 0; e_block = 0; e_miss = 0;
    if (release_valid) begin
      idx = find(release_key);
      if (idx >= 0) tbl.delete(idx);
      else e_miss = 1;
    end
    if (busy) begin
      age++;
      if (age == 3) begin
        if (m_dec) begin
          tbl.push_back(m_key);
          e_grant = 1;
          m_sg++;
        end else begin
          e_block = 1;
          m_sb++;
        end
      end else if (age > 3 && !proc_obtain_key) begin
        busy = 0;
      end
    end else if (proc_obtain_key) begin
      busy  = 1;
      age   = 1;
      m_key = proc_key;
      m_dec = (find(proc_key) < 0) && (tbl.size() < N);
    end
  endtask

  task automatic compare();
    check("grant", proc_key_grant, e_grant);
    check("blocked", proc_key_blocked, e_block);
    check("release_miss", release_miss, e_miss);
    check("num_locked", num_locked, tbl.size());
    check("locks_available", locks_available, tbl.size() < N);
`ifdef LOCK_KEY_TABLE_STATS_EN
    check("stat_grant", stat_grant_count, m_sg);
    check("stat_block", stat_block_count, m_sb);
`else
    check("stat_grant", stat_grant_count, 0);
    check("stat_block", stat_block_count, 0);
`endif
  endtask

  task automatic step(bit ob, logic [DW-1:0] k, bit rv, logic [DW-1:0] rk);
    proc_obtain_key = ob;
    proc_key        = k;
    release_valid   = rv;
    release_key     = rk;
    @(posedge clk);
    model_edge();
    #1 compare();
  endtask

  // Holds the request until a pulse; key is scrambled after the IDLE sample
  task automatic req(logic [DW-1:0] k, bit exp_g, string nm,
                     int rel_at = -1, logic [DW-1:0] rk = '0);
    int n;
    bit got;
    n = 0;
    got = 0;
    while (!got && n < 12) begin
      step(1'b1, (n == 0) ? k : ~k, n == rel_at, rk);
      n++;
      got = proc_key_grant | proc_key_blocked;
    end
    check({nm, "_latency"}, n, 3);
    check({nm, "_grant"}, proc_key_grant, exp_g);
    check({nm, "_blocked"}, proc_key_blocked, !exp_g);
    step(1'b0, '0, 1'b0, '0);
  endtask

  task automatic rel(logic [DW-1:0] k, bit exp_miss, string nm);
    step(1'b0, '0, 1'b1, k);
    check({nm, "_miss"}, release_miss, exp_miss);
  endtask

  task automatic check_reset_vals(string nm);
    check({nm, "_grant"}, proc_key_grant, 0);
    check({nm, "_blocked"}, proc_key_blocked, 0);
    check({nm, "_miss"}, release_miss, 0);
    check({nm, "_num"}, num_locked, 0);
    check({nm, "_avail"}, locks_available, 1);
    check({nm, "_sg"}, stat_grant_count, 0);
    check({nm, "_sb"}, stat_block_count, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit            ron, dropped, rv;
    int            held;
    logic [DW-1:0] kk, rk;

    reset = 1'b1;
    proc_obtain_key = 1'b0;
    proc_key = '0;
    release_valid = 1'b0;
    release_key = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_reset_vals("reset");
    reset = 1'b0;

    req(32'hA5, 1'b1, "a5_first");
    check("a5_num", num_locked, 1);
    check("a5_avail", locks_available, 1);
    req(32'hA5, 1'b0, "a5_held");
    check("a5_held_num", num_locked, 1);
    rel(32'hA5, 1'b0, "a5_rel");
    req(32'hA5, 1'b1, "a5_retry");
    rel(32'hA5, 1'b0, "a5_rel2");

    for (int i = 0; i < 8; i++) req(32'h10 + i, 1'b1, "fill");
    check("full_avail", locks_available, 0);
    check("full_num", num_locked, 8);
    req(32'h20, 1'b0, "full_block");
    rel(32'h13, 1'b0, "rel13");
    check("rel13_avail", locks_available, 1);
    req(32'h20, 1'b1, "refill20");
    check("refill_avail", locks_available, 0);

    rel(32'hDEAD, 1'b1, "dead");
    check("dead_num", num_locked, 8);

    rel(32'h14, 1'b0, "rel14");
    check("rel14_num", num_locked, 7);
    req(32'h30, 1'b1, "simul", 2, 32'h11);
    check("simul_num", num_locked, 7);
    rel(32'h11, 1'b1, "simul_11_gone");
    req(32'h30, 1'b0, "simul_30_held");

    // Reset while the request sits in LOOKUP
    step(1'b1, 32'h77, 1'b0, '0);
    reset = 1'b1;
    #1 check_reset_vals("rst_lookup");
    model_clear();
    proc_obtain_key = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 check_reset_vals("rst_hold");
    end
    reset = 1'b0;
    repeat (4) step(1'b0, '0, 1'b0, '0);

    req(32'h40, 1'b1, "st_g0");
    req(32'h41, 1'b1, "st_g1");
    req(32'h42, 1'b1, "st_g2");
    req(32'h40, 1'b0, "st_b0");
    req(32'h41, 1'b0, "st_b1");
`ifdef LOCK_KEY_TABLE_STATS_EN
    check("stat_grant3", stat_grant_count, 3);
    check("stat_block2", stat_block_count, 2);
`else
    check("stat_grant_off", stat_grant_count, 0);
    check("stat_block_off", stat_block_count, 0);
`endif

    ron = 0;
    dropped = 0;
    held = 0;
    for (int c = 0; c < 3000; c++) begin
      rv = ($urandom % 10) < 3;
      kk = 32'h50 + ($urandom % 12);
      rk = 32'h50 + ($urandom % 12);
      if (!ron && !dropped && ($urandom % 3) == 0) begin
        ron = 1;
        held = 0;
      end
      dropped = 0;
      step(ron, kk, rv, rk);
      if (ron) begin
        held++;
        if (proc_key_grant | proc_key_blocked) begin
          ron = 0;
          dropped = 1;
        end else if (held > 6) begin
          check("rand_resp_timeout", held, 3);
          ron = 0;
          dropped = 1;
        end
      end
    end
    repeat (3) step(1'b0, '0, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lock_key_table.md
Name: lock_key_table

Overview:
- Responder end of the key-lock handshake.
- Owns a table of NUM_LOCKS currently locked keys and answers each obtain request with a one-cycle grant or blocked pulse.
- Grants are refused if the key is already held or the table is full.
- Keys are freed by a separate release interface driven when the downstream write-back for that key completes.
- Advertises locks_available so the requester only pops work when a slot can be granted.

Parameters:
- DATA_WIDTH, 32, key width in bits.
- NUM_LOCKS, 8, number of lock slots (power of two, 2..64).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- proc_key  in  DATA_WIDTH  key to lock; valid while proc_obtain_key=1
- proc_obtain_key  in  1  level request; held until grant/blocked seen, then dropped by requester
- proc_key_grant  out  1  one-cycle pulse: key locked
- proc_key_blocked  out  1  one-cycle pulse: key held or table full
- locks_available  out  1  registered; 1 when at least one slot is free
- release_valid  in  1  one-cycle release strobe
- release_key  in  DATA_WIDTH  key to unlock
- release_miss  out  1  one-cycle pulse: released key not in table
- num_locked  out  log2(NUM_LOCKS)+1  registered count of valid slots
- stat_grant_count  out  32  see Optional Feature
- stat_block_count  out  32  see Optional Feature

Behaviour:
- Reset (async, active-high): all slots invalid, state IDLE, all pulses 0, num_locked=0, locks_available=1, stat counters 0. Reset mid-handshake abandons the request; no response is issued.
- Slot storage: per slot a valid bit and a DATA_WIDTH key register. Keys in valid slots are unique.
- FSM:
  - IDLE: if proc_obtain_key=1, latch proc_key into req_key and go to LOOKUP.
  - LOOKUP: compare req_key against all valid slots. Register hit (any match) and free_idx (lowest-index invalid slot) plus any_free. Go to RESPOND.
  - RESPOND: if hit=0 and any_free=1, write req_key into slot free_idx, set its valid bit, and pulse proc_key_grant. Otherwise pulse proc_key_blocked. Go to WAIT_DROP.
  - WAIT_DROP: stay until proc_obtain_key=0, then go to IDLE. A requester re-assertion after a retry therefore always starts a fresh IDLE→LOOKUP.
- Latency: request seen in IDLE → response pulse 3 cycles later (IDLE, LOOKUP, RESPOND registered output). Exactly one pulse per request; grant and blocked are never both 1.
- Release:
  - Processed every cycle, independent of FSM state.
  - release_valid=1 with a matching valid slot clears that slot's valid bit.
  - No match: table unchanged, release_miss pulses 1 cycle later.
- Simultaneous events:
  - Release and allocation in the same cycle both take effect; they are always different slots, because free_idx was invalid at LOOKUP.
  - A release during LOOKUP or RESPOND does not alter the registered hit/any_free decision. A resulting blocked response is conservative; the requester retries.
- num_locked: updated each cycle by +1 on allocation and −1 on a successful release (net 0 if both).
- locks_available: registered from the next-state valid bits, so it reflects allocation/release one cycle after they occur.
- proc_key is sampled only in IDLE; changes at other times are ignored.

Optional Feature:
- Macro: LOCK_KEY_TABLE_STATS_EN.
- Defined: stat_grant_count and stat_block_count increment by 1 on each grant/blocked pulse. Both saturate at 0xFFFFFFFF and are cleared only by reset.
- Undefined: no counter logic is built; both ports are tied to 0.

Test Plan:
- Key 0x0000_00A5 obtain on empty table → grant 3 cycles after request; num_locked=1; locks_available stays 1.
- Second obtain of 0x0000_00A5 while held → blocked pulse; num_locked stays 1. Release 0xA5, then retry → grant.
- Fill 8 distinct keys 0x10..0x17 → locks_available=0 one cycle after the 8th grant. Obtain 0x20 → blocked. Release 0x13, then obtain 0x20 → grant into slot 3.
- Release 0xDEAD not in table → release_miss pulse; num_locked unchanged.
- release_valid for 0x11 in the same cycle as RESPOND granting 0x30 → both take effect; num_locked unchanged net.
- Assert reset while in LOOKUP → no grant/blocked pulse; all outputs at reset values. With LOCK_KEY_TABLE_STATS_EN, 3 grants + 2 blocks → stat_grant_count=3, stat_block_count=2.
